// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: registered, handshaked ALU with an iterative RV32M
// multiply/divide unit.
//
// Base operations (codes 1-11) and unknown codes finish one cycle after
// accept. MUL/MULH/MULHSU/MULHU use a radix-2 shift-add datapath, and
// DIV/DIVU/REM/REMU use a radix-2 restoring shift-subtract datapath. Both work
// on operand magnitudes and fix the sign on the final step, so they finish
// WIDTH+1 cycles after accept. Divide-by-zero and signed overflow are resolved
// at accept with the base-op latency.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   data1/data2/ALUSel are valid
//   in_ready   block can accept an operation (IDLE)
//   data1      operand A (rs1)
//   data2      operand B (rs2 or immediate)
//   ALUSel     5-bit operation code
//   out_valid  ALUop holds a result (DONE)
//   out_ready  consumer accepts the result
//   ALUop      registered result
//   busy       iterative multiply/divide in progress (BUSY)
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready. An output transfer happens on a rising edge where
// out_valid && out_ready. in_valid is ignored while in_ready is low. The
// result and out_valid are held unchanged until the output transfer. The next
// input transfer can happen no earlier than the cycle after the output
// transfer.
module alu_mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [4:0]       ALUSel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUop,
    output logic             busy
);
    localparam int               SH_W      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] mq_q, mq_d;       // multiplier (product low half) / quotient
    logic [WIDTH-1:0] md_q, md_d;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0] res_q, res_d;
    logic             is_div_q, is_div_d;
    logic             neg_q, neg_d;     // negate the selected result at the end
    logic             sel_hi_q, sel_hi_d; // product high half, or remainder

    // Decode of the operation presented at the input.
    logic             is_mul, is_div_op, a_signed, b_signed, div_zero, div_ovf;
    logic [WIDTH-1:0] mag_a, mag_b, base_res, special_res;
    logic [SH_W-1:0]  shamt;

    assign shamt = data2[SH_W-1:0];

    always_comb begin
        is_mul    = (ALUSel >= 5'd12) && (ALUSel <= 5'd15);
        is_div_op = (ALUSel >= 5'd16) && (ALUSel <= 5'd19);
        a_signed  = ALUSel inside {5'd13, 5'd14, 5'd16, 5'd18};
        b_signed  = ALUSel inside {5'd13, 5'd16, 5'd18};
        mag_a     = (a_signed && data1[WIDTH-1]) ? -data1 : data1;
        mag_b     = (b_signed && data2[WIDTH-1]) ? -data2 : data2;
        div_zero  = (data2 == '0);
        div_ovf   = (ALUSel inside {5'd16, 5'd18}) && (data1 == MIN_VAL) && (data2 == '1);
        if (div_zero) begin
            special_res = (ALUSel inside {5'd16, 5'd17}) ? '1 : data1;
        end else begin
            special_res = (ALUSel == 5'd16) ? MIN_VAL : '0;
        end
    end

    always_comb begin
        base_res = '0;
        case (ALUSel)
            5'd1:    base_res = data1 + data2;
            5'd2:    base_res = data1 - data2;
            5'd3:    base_res = data1 << shamt;
            5'd4:    base_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
            5'd5:    base_res = {{(WIDTH-1){1'b0}}, data1 < data2};
            5'd6:    base_res = data1 ^ data2;
            5'd7:    base_res = data1 >> shamt;
            5'd8:    base_res = $signed(data1) >>> shamt;
            5'd9:    base_res = data1 | data2;
            5'd10:   base_res = data1 & data2;
            5'd11:   base_res = data2;
            default: base_res = '0;
        endcase
    end

    // One iteration step of either datapath, plus the sign-corrected final value
    // built from that step so the last step and correction share one edge.
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, step_acc, step_mq, div_pick, div_fix, fin_res;
    logic [2*WIDTH-1:0] prod, prod_fix;

    always_comb begin
        mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, md_q} : '0);
        div_sh   = {acc_q, mq_q[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, md_q});
        // When div_ge holds, the true difference is below md_q, so WIDTH bits suffice.
        div_diff = div_sh[WIDTH-1:0] - md_q;
        if (is_div_q) begin
            step_acc = div_ge ? div_diff : div_sh[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], div_ge};
        end else begin
            step_acc = mul_sum[WIDTH:1];
            step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
        prod     = {step_acc, step_mq};
        prod_fix = neg_q ? -prod : prod;
        div_pick = sel_hi_q ? step_acc : step_mq;
        div_fix  = neg_q ? -div_pick : div_pick;
        if (is_div_q) begin
            fin_res = div_fix;
        end else begin
            fin_res = sel_hi_q ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        md_d     = md_q;
        res_d    = res_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sel_hi_d = sel_hi_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_mul || (is_div_op && !div_zero && !div_ovf)) begin
                        state_d  = S_BUSY;
                        cnt_d    = CNT_START;
                        acc_d    = '0;
                        mq_d     = mag_a;
                        md_d     = mag_b;
                        is_div_d = is_div_op;
                        sel_hi_d = is_mul ? (ALUSel != 5'd12) : (ALUSel inside {5'd18, 5'd19});
                        // Quotient and product take the sign XOR; remainder and
                        // MULHSU follow data1 alone.
                        case (ALUSel)
                            5'd13, 5'd16: neg_d = data1[WIDTH-1] ^ data2[WIDTH-1];
                            5'd14, 5'd18: neg_d = data1[WIDTH-1];
                            default:      neg_d = 1'b0;
                        endcase
                    end else begin
                        state_d = S_DONE;
                        res_d   = is_div_op ? special_res : base_res;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                acc_d = step_acc;
                mq_d  = step_mq;
                if (cnt_q == CNT_ONE) begin
                    res_d   = fin_res;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            md_q     <= '0;
            res_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            md_q     <= md_d;
            res_q    <= res_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sel_hi_q <= sel_hi_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign ALUop     = res_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Testbench for alu_mdu_seq (WIDTH=32): directed cases from the operation table
// plus randomized operations and randomized out_ready back-pressure. Results and
// timing are predicted by a behavioural model using 64-bit arithmetic and
// per-operation latency.
module tb_alu_mdu_seq;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [4:0]  ALUSel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUop;
    logic        busy;

    int cmp_cnt = 0;
    int err_cnt = 0;

    alu_mdu_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data1    (data1),
        .data2    (data2),
        .ALUSel   (ALUSel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALUop    (ALUop),
        .busy     (busy)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, ub_s;
        longint unsigned ua, ub;
        logic signed [63:0] p;
        logic [63:0]     up;
        logic [31:0]     r;
        logic [4:0]      sh;
        sa   = $signed(a);
        sb   = $signed(b);
        ua   = {32'd0, a};
        ub   = {32'd0, b};
        ub_s = {32'd0, b};
        sh   = b[4:0];
        r    = 32'd0;
        case (op)
            5'd1:  r = a + b;
            5'd2:  r = a - b;
            5'd3:  r = a << sh;
            5'd4:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd5:  r = (a < b) ? 32'd1 : 32'd0;
            5'd6:  r = a ^ b;
            5'd7:  r = a >> sh;
            5'd8:  begin p = sa >>> sh; r = p[31:0]; end
            5'd9:  r = a | b;
            5'd10: r = a & b;
            5'd11: r = b;
            5'd12: begin up = ua * ub; r = up[31:0]; end
            5'd13: begin p = sa * sb; r = p[63:32]; end
            5'd14: begin p = sa * ub_s; r = p[63:32]; end
            5'd15: begin up = ua * ub; r = up[63:32]; end
            5'd16: if (b == 32'd0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
            5'd17: if (b == 32'd0) r = 32'hFFFF_FFFF; else r = a / b;
            5'd18: if (b == 32'd0) r = a; else begin p = sa % sb; r = p[31:0]; end
            5'd19: if (b == 32'd0) r = a; else r = a % b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Cycles from accept to the first cycle showing out_valid.
    function automatic int model_lat(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
        if (op >= 5'd12 && op <= 5'd15) return 33;
        if (op >= 5'd16 && op <= 5'd19) begin
            if (b == 32'd0) return 1;
            if ((op == 5'd16 || op == 5'd18) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
        return 1;
    endfunction

    // ---------------- scoreboard / transaction tracking ----------------
    logic [31:0] exp_q[$];
    int  cyc      = 0;
    int  acc_cyc  = 0;
    int  exp_lat  = 1;
    bit  pend     = 1'b0;
    bit  started  = 1'b0;
    bit  clean    = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            started = 1'b1;
            clean   = 1'b1;
            pend    = 1'b0;
            exp_q.delete();
        end else if (pend) begin
            if ((cyc - acc_cyc + 1) >= exp_lat && out_ready) begin
                pend = 1'b0;
                void'(exp_q.pop_front());
            end
        end else if (in_valid) begin
            exp_q.push_back(model(ALUSel, data1, data2));
            exp_lat = model_lat(ALUSel, data1, data2);
            acc_cyc = cyc + 1;
            pend    = 1'b1;
            clean   = 1'b0;
        end
        cyc = cyc + 1;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: checks every output on every cycle against the model.
    task automatic monitor_loop();
        int since;
        forever begin
            @(negedge clk);
            if (started) begin
                if (!pend) begin
                    chk1("idle_in_ready", in_ready, 1'b1);
                    chk1("idle_out_valid", out_valid, 1'b0);
                    chk1("idle_busy", busy, 1'b0);
                    if (clean) chk32("reset_aluop", ALUop, 32'd0);
                end else begin
                    since = cyc - acc_cyc + 1;
                    if (since < exp_lat) begin
                        chk1("wait_out_valid", out_valid, 1'b0);
                        chk1("wait_in_ready", in_ready, 1'b0);
                        chk1("wait_busy", busy, exp_lat > 1);
                    end else begin
                        chk1("done_out_valid", out_valid, 1'b1);
                        chk1("done_in_ready", in_ready, 1'b0);
                        chk1("done_busy", busy, 1'b0);
                        chk32("result", ALUop, exp_q[0]);
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 (t=%0t)", $time);
        end
        in_valid = 1'b1;
        ALUSel   = op;
        data1    = a;
        data2    = b;
        @(posedge clk); #1;
        // Scramble inputs after accept; the captured operation must be unaffected.
        in_valid = 1'b0;
        ALUSel   = 5'($urandom_range(0, 31));
        data1    = $urandom;
        data2    = $urandom;
    endtask

    task automatic wait_done(input bit rnd);
        int n;
        bit hs;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            data1     = $urandom;
            data2     = $urandom;
            hs        = out_valid && out_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!hs) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL done_timeout: handshake got 0 expected 1 (t=%0t)", $time);
        end
    endtask

    task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pin);
        chk32({"pin_", name}, model(op, a, b), pin);
        send(op, a, b);
        wait_done(1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data1     = 32'd0;
        data2     = 32'd0;
        ALUSel    = 5'd0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Base operations
        do_op("add_wrap", 5'd1,  32'h7FFF_FFFF, 32'd1,         32'h8000_0000);
        do_op("sra",      5'd8,  32'h8000_0000, 32'd4,         32'hF800_0000);
        do_op("sltu",     5'd5,  32'd1,         32'hFFFF_FFFF, 32'd1);
        do_op("slt",      5'd4,  32'hFFFF_FFFF, 32'd1,         32'd1);
        do_op("sll",      5'd3,  32'd1,         32'd31,        32'h8000_0000);
        do_op("srl",      5'd7,  32'h8000_0000, 32'd36,        32'h0800_0000);
        do_op("sub",      5'd2,  32'd0,         32'd1,         32'hFFFF_FFFF);
        do_op("lui",      5'd11, 32'd5,         32'h1234_5000, 32'h1234_5000);
        // Multiply
        do_op("mulhu",    5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op("mul",      5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        do_op("mulh",     5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op("mulhsu",   5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        // Divide
        do_op("div",      5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        do_op("rem",      5'd18, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        do_op("divu",     5'd17, 32'd100,       32'd7,         32'd14);
        do_op("remu",     5'd19, 32'd100,       32'd7,         32'd2);
        do_op("div0",     5'd16, 32'd5,         32'd0,         32'hFFFF_FFFF);
        do_op("rem0",     5'd18, 32'd5,         32'd0,         32'd5);
        do_op("div_ovf",  5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op("rem_ovf",  5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        do_op("unk0",     5'd0,  32'd9,         32'd9,         32'd0);

        // Result held under back-pressure; in_valid pulses must be ignored.
        out_ready = 1'b0;
        send(5'd1, 32'd10, 32'd20);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            ALUSel   = 5'd1;
            data1    = $urandom;
            data2    = $urandom;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset in the middle of a DIVU aborts it.
        send(5'd17, 32'd1000, 32'd7);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op("add_after_rst", 5'd1,  32'd2, 32'd3, 32'd5);
        do_op("unk25",         5'd25, 32'd7, 32'd8, 32'd0);

        // Randomized operations with random back-pressure.
        for (int i = 0; i < 80; i++) begin
            send(5'($urandom_range(0, 31)), rnd_operand(), rnd_operand());
            wait_done(1'b1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Registered, handshaked successor to the single-cycle combinational ALU.
- Keeps the base ALU operation codes 1–11 unchanged, widened to a 5-bit selector.
- Adds the RV32M multiply/divide family using iterative radix-2 datapaths.
- Sits between decode/operand-read and writeback of the multi-cycle core; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand and result width; ≥8, power of two; shift amount uses low log2(WIDTH) bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  block can accept an operation.
- data1  input  WIDTH  operand A (rs1).
- data2  input  WIDTH  operand B (rs2 or immediate).
- ALUSel  input  5  operation code.
- out_valid  output  1  ALUop holds a result.
- out_ready  input  1  consumer accepts the result.
- ALUop  output  WIDTH  result.
- busy  output  1  iterative operation in progress.

Behaviour:
- Reset (rst_n=0 at a clk edge) applies to every output:
  - State goes to IDLE; out_valid=0, ALUop=0, busy=0, in_ready=1 after the edge.
  - Counter and internal registers are cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- Operation codes:
  - 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND, 11 PASS data2 (LUI).
  - 12 MUL (low WIDTH), 13 MULH (s×s high), 14 MULHSU (s×u high), 15 MULHU (u×u high).
  - 16 DIV, 17 DIVU, 18 REM, 19 REMU.
  - Codes 0 and 20–31 give ALUop=0 with the same timing as base ops; no error flag.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - SLT/SLTU give zero-extended 0/1.
  - SRA sign-fills from data1[WIDTH-1].
- FSM states:
  - IDLE: in_ready=1. Accept on in_valid&in_ready.
    - Base or unknown op: compute, register result, go to DONE (result visible in the cycle after accept, latency 1).
    - Mul/div op: latch magnitudes and sign info, counter=WIDTH, go to BUSY.
  - BUSY: in_ready=0, busy=1. One shift-add (mul) or restoring shift-subtract (div) step per cycle. Counter decrements each cycle; when it reaches 0, apply sign correction and go to DONE.
    - Mul/div latency is WIDTH+1 cycles from accept to out_valid (33 at WIDTH=32).
  - DONE: out_valid=1, ALUop stable, in_ready=0. On out_ready go to IDLE.
    - A new op is accepted no earlier than the cycle after the result handshake; no back-to-back overlap.
- Division boundary cases, resolved at accept with latency 1 (no BUSY):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = data1.
  - Signed overflow (DIV with data1=MIN, data2=-1): quotient=MIN, REM=0.
- Sign handling:
  - Signed ops operate on magnitudes.
  - Quotient is negated if operand signs differ; remainder takes the dividend's sign.
  - MULHSU treats only data1 as signed.
- Held signals:
  - out_valid held with out_ready=0: ALUop must not change; stays in DONE indefinitely.
  - in_valid while not in_ready: ignored; inputs need not be held by the producer.
- Operand capture: data1/data2/ALUSel are sampled only at the accept edge; later changes have no effect.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 (out_ready=1) -> out_valid the cycle after accept, ALUop=0x80000000; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles; MUL same operands -> 0x00000001; MULH -1×-1 -> 0x00000000; MULHSU -1×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; busy=1 and in_ready=0 throughout BUSY.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each at 1-cycle latency; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
- out_ready=0 for 10 cycles after a result -> out_valid stays 1, ALUop unchanged, in_valid pulses ignored; release -> IDLE next cycle.
- rst_n=0 at cycle 10 of a DIVU -> the next cycle shows out_valid=0, ALUop=0, in_ready=1; a subsequent ADD 2+3 -> 5 with normal timing; unknown code 25 -> 0.
